// File: rtl/ifq_icache_pkg.sv
// Shared types and sizing for the IFQ instruction-cache controller.
package ifq_icache_pkg;

   typedef enum logic [2:0] {IDLE, LOOKUP, MEM_REQ, REFILL, RESP} state_t;

   localparam int LINE_W         = 128;
   localparam int WORDS_PER_LINE = 4;

   function automatic int tag_w(input int addr_w, input int idx_w);
      return addr_w - 2 - idx_w;
   endfunction

endpackage

// File: rtl/icache_tag_data_array.sv
// Valid bits with bulk clear, plus tag/data RAMs with registered read and one write port.
module icache_tag_data_array
   import ifq_icache_pkg::*;
#(
   parameter int IDX_W = 4,
   parameter int TAG_W = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [IDX_W-1:0]  rd_idx,
   output logic              rd_valid,
   output logic [TAG_W-1:0]  rd_tag,
   output logic [LINE_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [LINE_W-1:0] wr_data,
   input  logic              clr_all
);

   localparam int LINES = 2 ** IDX_W;

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_ram  [LINES];
   logic [LINE_W-1:0] data_ram [LINES];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (clr_all)
            valid <= '0;
         else if (wr_en)
            valid[wr_idx] <= 1'b1;
         if (rd_en)
            rd_valid <= valid[rd_idx];
      end
   end

   // RAM contents need no reset: a line is only trusted once its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_ram[wr_idx]  <= wr_tag;
         data_ram[wr_idx] <= wr_data;
      end
      if (rd_en) begin
         rd_tag  <= tag_ram[rd_idx];
         rd_data <= data_ram[rd_idx];
      end
   end

endmodule

// File: rtl/ifq_icache_ctrl.sv
// Direct-mapped I-cache controller: lookup, 4-beat refill, redirect kill and bulk invalidate.
module ifq_icache_ctrl
   import ifq_icache_pkg::*;
#(
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] Pc_in,
   input  logic              Rd_en_cache,
   input  logic              Jmp_branch_valid,
   input  logic              Inv_all,
   output logic [LINE_W-1:0] Dout,
   output logic              Dout_valid,
   output logic              Mem_rd,
   output logic [ADDR_W-1:0] Mem_addr,
   input  logic              Mem_ack,
   input  logic [31:0]       Mem_data,
   input  logic              Mem_valid,
   output logic              Busy
);

   localparam int TAG_W = tag_w(ADDR_W, IDX_W);

   state_t            state;
   logic [IDX_W-1:0]  req_idx;
   logic [TAG_W-1:0]  req_tag;
   logic [1:0]        beat_cnt;
   logic              kill;
   logic              inv_pend;
   logic [LINE_W-1:0] refill_buf;
   logic [LINE_W-1:0] dout_hold;

   logic              rd_valid;
   logic [TAG_W-1:0]  rd_tag;
   logic [LINE_W-1:0] rd_data;
   logic              accept, inv_clear, hit, last_beat;
   logic [LINE_W-1:0] fill_line, line;

   assign accept    = (state == IDLE) && Rd_en_cache && !Jmp_branch_valid && !inv_pend;
   assign inv_clear = (state == IDLE) && inv_pend;
   assign hit       = rd_valid && (rd_tag == req_tag);
   assign last_beat = (state == REFILL) && Mem_valid && (beat_cnt == 2'd3);
   assign fill_line = {Mem_data, refill_buf[LINE_W-33:0]};
   assign line      = (state == RESP) ? refill_buf : rd_data;

   // Response is combinational in LOOKUP/RESP so a hit returns one cycle after the request.
   always_comb begin
      Dout_valid = 1'b0;
      if (state == LOOKUP)
         Dout_valid = hit && !Jmp_branch_valid;
      else if (state == RESP)
         Dout_valid = !kill && !Jmp_branch_valid;
   end

   assign Dout = Dout_valid ? line : dout_hold;
   assign Busy = (state != IDLE) || inv_pend;

   icache_tag_data_array #(.IDX_W(IDX_W), .TAG_W(TAG_W)) u_array (
      .clk      (clk),
      .reset    (reset),
      .rd_en    (accept),
      .rd_idx   (Pc_in[IDX_W+1:2]),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_en    (last_beat),
      .wr_idx   (req_idx),
      .wr_tag   (req_tag),
      .wr_data  (fill_line),
      .clr_all  (inv_clear)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         req_idx    <= '0;
         req_tag    <= '0;
         beat_cnt   <= '0;
         kill       <= 1'b0;
         inv_pend   <= 1'b0;
         refill_buf <= '0;
         dout_hold  <= '0;
         Mem_rd     <= 1'b0;
         Mem_addr   <= '0;
      end else begin
         if (Inv_all)
            inv_pend <= 1'b1;
         else if (inv_clear)
            inv_pend <= 1'b0;
         if (Dout_valid)
            dout_hold <= line;
         case (state)
            IDLE: begin
               if (accept) begin
                  req_idx  <= Pc_in[IDX_W+1:2];
                  req_tag  <= Pc_in[ADDR_W-1:IDX_W+2];
                  Mem_addr <= Pc_in & ~ADDR_W'(3);
                  state    <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (Jmp_branch_valid || hit) begin
                  state <= IDLE;
               end else begin
                  Mem_rd <= 1'b1;
                  state  <= MEM_REQ;
               end
            end
            MEM_REQ: begin
               if (Jmp_branch_valid)
                  kill <= 1'b1;
               if (Mem_ack) begin
                  Mem_rd   <= 1'b0;
                  beat_cnt <= 2'd0;
                  state    <= REFILL;
               end
            end
            REFILL: begin
               if (Jmp_branch_valid)
                  kill <= 1'b1;
               if (Mem_valid) begin
                  refill_buf[32*beat_cnt +: 32] <= Mem_data;
                  beat_cnt <= beat_cnt + 2'd1;
                  if (beat_cnt == 2'd3)
                     state <= RESP;
               end
            end
            RESP: begin
               kill  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ifq_icache_ctrl.sv
// Directed bench: a cycle table for cold miss + re-hit, then hand sequences for kill, invalidate, conflict and reset.
module tb_ifq_icache_ctrl;
   logic         clk = 1'b0;
   logic         reset;
   logic [31:0]  Pc_in;
   logic         Rd_en_cache, Jmp_branch_valid, Inv_all;
   logic [127:0] Dout;
   logic         Dout_valid, Mem_rd;
   logic [31:0]  Mem_addr;
   logic         Mem_ack;
   logic [31:0]  Mem_data;
   logic         Mem_valid, Busy;

   int checks = 0;
   int failures = 0;

   ifq_icache_ctrl #(.IDX_W(4), .ADDR_W(32)) dut (
      .clk(clk), .reset(reset), .Pc_in(Pc_in), .Rd_en_cache(Rd_en_cache),
      .Jmp_branch_valid(Jmp_branch_valid), .Inv_all(Inv_all), .Dout(Dout),
      .Dout_valid(Dout_valid), .Mem_rd(Mem_rd), .Mem_addr(Mem_addr),
      .Mem_ack(Mem_ack), .Mem_data(Mem_data), .Mem_valid(Mem_valid), .Busy(Busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         rd;
      logic         ack;
      logic         mv;
      logic [31:0]  md;
      logic         e_dv;
      logic         e_mrd;
      logic         e_busy;
      logic [31:0]  e_addr;
      logic [127:0] e_dout;
   } vec_t;

   vec_t vec [14];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] mk_line(input logic [31:0] base);
      return {base + 32'd3, base + 32'd2, base + 32'd1, base};
   endfunction

   // Request, sample Dout_valid/Dout in LOOKUP, then Mem_rd one cycle later.
   task automatic lookup(input logic [31:0] pc, output logic dv, output logic [127:0] dout,
                         output logic mrd);
      @(posedge clk); #1; Pc_in = pc; Rd_en_cache = 1'b1; #1;
      @(posedge clk); #1; Rd_en_cache = 1'b0; #1; dv = Dout_valid; dout = Dout;
      @(posedge clk); #2; mrd = Mem_rd;
      $display("lookup pc=%h dv=%0b mem_rd=%0b", pc, dv, mrd);
   endtask

   // From MEM_REQ: ack, four back-to-back beats (optional redirect/invalidate on a beat), RESP, IDLE.
   task automatic refill(input logic [31:0] base, input int jb, input int ib, output logic dv,
                         output logic [127:0] dout, output logic busy_idle);
      @(posedge clk); #1; Mem_ack = 1'b1; #1;
      for (int b = 0; b < 4; b++) begin
         @(posedge clk); #1;
         Mem_ack = 1'b0; Mem_valid = 1'b1; Mem_data = base + 32'(b);
         Jmp_branch_valid = (b == jb); Inv_all = (b == ib); #1;
      end
      @(posedge clk); #1; Mem_valid = 1'b0; Jmp_branch_valid = 1'b0; Inv_all = 1'b0; #1;
      dv = Dout_valid; dout = Dout;
      @(posedge clk); #2; busy_idle = Busy;
      $display("refill base=%h dv=%0b dout=%h", base, dv, dout);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic         dv, mrd, bi;
      logic [127:0] d;
      logic [127:0] l1;
      l1 = 128'h00000044_00000033_00000022_00000011;
      //          rd ack mv md        dv mrd busy addr         dout
      vec[0]  = '{1, 0, 0, 32'h0,  0, 0, 0, 32'h0,  128'h0};
      vec[1]  = '{0, 0, 0, 32'h0,  0, 0, 1, 32'h10, 128'h0};
      vec[2]  = '{0, 0, 0, 32'h0,  0, 1, 1, 32'h10, 128'h0};
      vec[3]  = '{0, 1, 0, 32'h0,  0, 1, 1, 32'h10, 128'h0};
      vec[4]  = '{0, 0, 1, 32'h11, 0, 0, 1, 32'h10, 128'h0};
      vec[5]  = '{0, 0, 0, 32'h0,  0, 0, 1, 32'h10, 128'h0};
      vec[6]  = '{0, 0, 1, 32'h22, 0, 0, 1, 32'h10, 128'h0};
      vec[7]  = '{0, 0, 1, 32'h33, 0, 0, 1, 32'h10, 128'h0};
      vec[8]  = '{0, 0, 1, 32'h44, 0, 0, 1, 32'h10, 128'h0};
      vec[9]  = '{0, 0, 0, 32'h0,  1, 0, 1, 32'h10, l1};
      vec[10] = '{0, 0, 0, 32'h0,  0, 0, 0, 32'h10, l1};
      vec[11] = '{1, 0, 0, 32'h0,  0, 0, 0, 32'h10, l1};
      vec[12] = '{0, 0, 0, 32'h0,  1, 0, 1, 32'h10, l1};
      vec[13] = '{0, 0, 0, 32'h0,  0, 0, 0, 32'h10, l1};

      reset = 1'b1; Pc_in = 32'h10; Rd_en_cache = 0; Jmp_branch_valid = 0; Inv_all = 0;
      Mem_ack = 0; Mem_data = 0; Mem_valid = 0;
      repeat (3) @(posedge clk);
      #1; reset = 1'b0;

      // Tests 1-2: cold miss with a gap between beats, then re-hit.
      for (int i = 0; i < 14; i++) begin
         @(posedge clk); #1;
         Rd_en_cache = vec[i].rd; Mem_ack = vec[i].ack; Mem_valid = vec[i].mv; Mem_data = vec[i].md;
         #1;
         chk($sformatf("v%0d_dv", i),   128'(Dout_valid), 128'(vec[i].e_dv));
         chk($sformatf("v%0d_mrd", i),  128'(Mem_rd),     128'(vec[i].e_mrd));
         chk($sformatf("v%0d_busy", i), 128'(Busy),       128'(vec[i].e_busy));
         chk($sformatf("v%0d_addr", i), 128'(Mem_addr),   128'(vec[i].e_addr));
         chk($sformatf("v%0d_dout", i), Dout,             vec[i].e_dout);
         $display("vec %0d dv=%0b mem_rd=%0b busy=%0b", i, Dout_valid, Mem_rd, Busy);
      end
      Rd_en_cache = 0; Mem_ack = 0; Mem_valid = 0;

      // Test 3: redirect on beat 2 kills the response but the line is still filled.
      lookup(32'h20, dv, d, mrd);
      chk("t3_miss_dv", 128'(dv), 128'(0));
      chk("t3_miss_mrd", 128'(mrd), 128'(1));
      chk("t3_addr", 128'(Mem_addr), 128'h20);
      refill(32'hA0, 2, -1, dv, d, bi);
      chk("t3_killed_dv", 128'(dv), 128'(0));
      chk("t3_idle_busy", 128'(bi), 128'(0));
      lookup(32'h20, dv, d, mrd);
      chk("t3_hit_dv", 128'(dv), 128'(1));
      chk("t3_hit_dout", d, mk_line(32'hA0));
      chk("t3_hit_mrd", 128'(mrd), 128'(0));

      // Test 4a: invalidate in IDLE blocks the same-cycle request, then clears.
      @(posedge clk); #1; Inv_all = 1'b1; #1;
      chk("t4_busy_pulse", 128'(Busy), 128'(0));
      @(posedge clk); #1; Inv_all = 1'b0; Pc_in = 32'h10; Rd_en_cache = 1'b1; #1;
      chk("t4_busy_pend", 128'(Busy), 128'(1));
      @(posedge clk); #1; Rd_en_cache = 1'b0; #1;
      chk("t4_busy_clr", 128'(Busy), 128'(0));
      lookup(32'h10, dv, d, mrd);
      chk("t4_inv_miss_dv", 128'(dv), 128'(0));
      chk("t4_inv_miss_mrd", 128'(mrd), 128'(1));
      // Test 4b: invalidate during refill takes effect only once back in IDLE.
      refill(32'hB0, -1, 1, dv, d, bi);
      chk("t4_resp_dv", 128'(dv), 128'(1));
      chk("t4_resp_dout", d, mk_line(32'hB0));
      chk("t4_idle_busy", 128'(bi), 128'(1));
      lookup(32'h10, dv, d, mrd);
      chk("t4_after_inv_dv", 128'(dv), 128'(0));
      chk("t4_after_inv_mrd", 128'(mrd), 128'(1));
      refill(32'hB0, -1, -1, dv, d, bi);
      chk("t4_refill2_dv", 128'(dv), 128'(1));
      chk("t4_refill2_busy", 128'(bi), 128'(0));

      // Test 5: same index, different tag evicts the resident line.
      lookup(32'h50, dv, d, mrd);
      chk("t5_miss_mrd", 128'(mrd), 128'(1));
      chk("t5_addr", 128'(Mem_addr), 128'h50);
      refill(32'hC0, -1, -1, dv, d, bi);
      chk("t5_resp_dout", d, mk_line(32'hC0));
      lookup(32'h10, dv, d, mrd);
      chk("t5_evicted_dv", 128'(dv), 128'(0));
      chk("t5_evicted_mrd", 128'(mrd), 128'(1));
      refill(32'hB0, -1, -1, dv, d, bi);
      chk("t5_refill_dv", 128'(dv), 128'(1));

      // Test 6: reset mid-refill.
      lookup(32'h30, dv, d, mrd);
      chk("t6_miss_mrd", 128'(mrd), 128'(1));
      @(posedge clk); #1; Mem_ack = 1'b1;
      @(posedge clk); #1; Mem_ack = 1'b0; Mem_valid = 1'b1; Mem_data = 32'hD0;
      @(posedge clk); #1; Mem_data = 32'hD1;
      #1; reset = 1'b1; #1;
      chk("t6_rst_mrd", 128'(Mem_rd), 128'(0));
      chk("t6_rst_dv", 128'(Dout_valid), 128'(0));
      chk("t6_rst_busy", 128'(Busy), 128'(0));
      chk("t6_rst_dout", Dout, 128'h0);
      chk("t6_rst_addr", 128'(Mem_addr), 128'h0);
      Mem_valid = 1'b0;
      @(posedge clk); #1; reset = 1'b0;
      lookup(32'h10, dv, d, mrd);
      chk("t6_post_dv", 128'(dv), 128'(0));
      chk("t6_post_mrd", 128'(mrd), 128'(1));
      refill(32'hE0, -1, -1, dv, d, bi);
      chk("t6_refill_dout", d, mk_line(32'hE0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
